// File: rtl/pe_acc_pkg.sv
// Shared state encoding and default sizing for the PE product accumulator.
package pe_acc_pkg;

    localparam int PE_N_DEF        = 16;
    localparam int PE_MULT_LAT_DEF = 3;
    localparam int PE_ACC_W_DEF    = 40;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } acc_state_t;

endpackage

// File: rtl/pe_result_fifo.sv
// Two-entry result buffer; ent0 is always the head, so dout needs no read mux.
module pe_result_fifo #(
    parameter int W = 41
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic [1:0]   count
);

    logic [W-1:0] ent0, ent1;
    logic         do_pop, do_push;

    assign do_pop  = pop && (count != 2'd0);
    assign do_push = push && ((count != 2'd2) || do_pop);
    assign dout    = ent0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ent0  <= '0;
            ent1  <= '0;
            count <= 2'd0;
        end else begin
            case ({do_push, do_pop})
                2'b10: begin
                    if (count == 2'd0) ent0 <= din;
                    else               ent1 <= din;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    ent0  <= ent1;
                    count <= count - 2'd1;
                end
                // Simultaneous push/pop: occupancy unchanged, pushed value queues behind survivors.
                2'b11: begin
                    if (count == 2'd1) begin
                        ent0 <= din;
                    end else begin
                        ent0 <= ent1;
                        ent1 <= din;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/pe_product_accumulator.sv
// Dot-product accumulator behind a fixed-latency multiplier, with a 2-entry result buffer.
// Define PE_ACC_SATURATE_EN to clamp the accumulator on overflow instead of wrapping.
module pe_product_accumulator
    import pe_acc_pkg::*;
#(
    parameter int N        = PE_N_DEF,
    parameter int MULT_LAT = PE_MULT_LAT_DEF,
    parameter int ACC_W    = PE_ACC_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    input  logic [2*N-1:0]   prod,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic             out_ovf,
    output logic             err_drop
);

    localparam int PW = 2 * N;
    localparam int CW = $clog2(MULT_LAT + 4);

    acc_state_t        state;
    logic [ACC_W-1:0]  acc, acc_nxt, addend, sext, sum;
    logic              ovf_acc, ovf_now, ovf_nxt;
    logic [MULT_LAT:1] vld_pipe, last_pipe;
    logic              issue, tag_vld, tag_last, push;
    logic [CW-1:0]     lasts_inflight;
    logic [1:0]        fifo_count;

    assign issue    = in_valid && in_ready;
    assign tag_vld  = vld_pipe[MULT_LAT];
    assign tag_last = last_pipe[MULT_LAT];

    // Tag delay line: stage MULT_LAT lines up with prod for the same issue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe  <= '0;
            last_pipe <= '0;
        end else begin
            vld_pipe[1]  <= issue;
            last_pipe[1] <= issue && in_last;
            for (int i = 2; i <= MULT_LAT; i++) begin
                vld_pipe[i]  <= vld_pipe[i-1];
                last_pipe[i] <= last_pipe[i-1];
            end
        end
    end

    always_comb begin
        lasts_inflight = '0;
        for (int i = 1; i <= MULT_LAT; i++)
            lasts_inflight = lasts_inflight + CW'(vld_pipe[i] && last_pipe[i]);
    end

    // Every in-flight last will claim a buffer slot, so reserve them up front.
    assign in_ready = (CW'(fifo_count) + lasts_inflight) < CW'(2);

    assign sext    = {{(ACC_W-PW){prod[PW-1]}}, prod};
    assign addend  = (state == ACCUM) ? acc : '0;
    assign sum     = addend + sext;
    assign ovf_now = (addend[ACC_W-1] == sext[ACC_W-1]) && (sum[ACC_W-1] != addend[ACC_W-1]);
    assign ovf_nxt = ((state == ACCUM) && ovf_acc) || ovf_now;

`ifdef PE_ACC_SATURATE_EN
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    assign acc_nxt = ovf_now ? (addend[ACC_W-1] ? ACC_MIN : ACC_MAX) : sum;
`else
    assign acc_nxt = sum;
`endif

    assign push = tag_vld && tag_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            acc     <= '0;
            ovf_acc <= 1'b0;
        end else if (tag_vld) begin
            if (tag_last) begin
                state   <= IDLE;
                acc     <= '0;
                ovf_acc <= 1'b0;
            end else begin
                state   <= ACCUM;
                acc     <= acc_nxt;
                ovf_acc <= ovf_nxt;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                       err_drop <= 1'b0;
        else if (in_valid && !in_ready) err_drop <= 1'b1;
    end

    pe_result_fifo #(
        .W(ACC_W + 1)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .din  ({ovf_nxt, acc_nxt}),
        .pop  (out_ready),
        .dout ({out_ovf, out_data}),
        .count(fifo_count)
    );

    assign out_valid = (fifo_count != 2'd0);

endmodule

// File: tb/tb_pe_product_accumulator.sv
// Randomized self-checking bench for pe_product_accumulator against an arithmetic dot-product model.
module tb_pe_product_accumulator;

    localparam int N   = 16;
    localparam int ML  = 3;
    localparam int AW  = 40;
    localparam int AW2 = 34;

    logic clk = 1'b0;
    logic rst;
    logic in_valid, in_last, in_ready, out_valid, out_ready, out_ovf, err_drop;
    logic [2*N-1:0] prod, pin;
    logic [AW-1:0]  out_data;
    logic [2*N-1:0] pd [ML];

    logic b_valid, b_last, b_rdy, b_ovalid, b_oready, b_ovf, b_err;
    logic [2*N-1:0] b_prod, b_pin;
    logic [AW2-1:0] b_data;
    logic [2*N-1:0] bpd [ML];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Behavioural multiplier: whatever is issued reappears ML cycles later.
    always @(posedge clk) begin
        pd[0]  <= in_valid ? pin : '0;
        bpd[0] <= b_valid ? b_pin : '0;
        for (int i = 1; i < ML; i++) begin
            pd[i]  <= pd[i-1];
            bpd[i] <= bpd[i-1];
        end
    end
    assign prod   = pd[ML-1];
    assign b_prod = bpd[ML-1];

    pe_product_accumulator #(.N(N), .MULT_LAT(ML), .ACC_W(AW)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .prod(prod), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_ovf(out_ovf), .err_drop(err_drop));

    pe_product_accumulator #(.N(N), .MULT_LAT(ML), .ACC_W(AW2)) u_dut34 (
        .clk(clk), .rst(rst), .in_valid(b_valid), .in_last(b_last), .in_ready(b_rdy),
        .prod(b_prod), .out_valid(b_ovalid), .out_ready(b_oready), .out_data(b_data),
        .out_ovf(b_ovf), .err_drop(b_err));

    function automatic longint wrapw(input longint x, input int w);
        longint v;
        v = x <<< (64 - w);
        return v >>> (64 - w);
    endfunction

    function automatic void model_dot(input longint t[$], input int w, output longint res, output bit ovf);
        longint acc, ex, mx, mn;
        mx  = (64'sd1 <<< (w - 1)) - 1;
        mn  = -(64'sd1 <<< (w - 1));
        acc = 0;
        ovf = 1'b0;
        foreach (t[i]) begin
            ex = acc + t[i];
            if (ex > mx || ex < mn) begin
                ovf = 1'b1;
`ifdef PE_ACC_SATURATE_EN
                acc = (ex > mx) ? mx : mn;
`else
                acc = wrapw(ex, w);
`endif
            end else begin
                acc = ex;
            end
        end
        res = acc;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input longint p, input bit last);
        in_valid = 1'b1; in_last = last; pin = p[2*N-1:0];
        tick();
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic issue_b(input longint p, input bit last);
        b_valid = 1'b1; b_last = last; b_pin = p[2*N-1:0];
        tick();
        b_valid = 1'b0; b_last = 1'b0;
    endtask

    task automatic pop();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic wait_out(input string name, output bit ok);
        int n = 0;
        while (!out_valid && n < 50) begin tick(); n++; end
        ok = out_valid;
        if (!ok) begin
            checks++; errors++;
            $display("FAIL %s timeout: out_valid=%0b expected 1", name, out_valid);
        end
    endtask

    task automatic wait_b(input string name, output bit ok);
        int n = 0;
        while (!b_ovalid && n < 50) begin tick(); n++; end
        ok = b_ovalid;
        if (!ok) begin
            checks++; errors++;
            $display("FAIL %s timeout: out_valid=%0b expected 1", name, b_ovalid);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        checks += 5;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        if (out_data !== '0)    begin errors++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
        if (out_ovf !== 1'b0)   begin errors++; $display("FAIL reset_out_ovf: got %b expected 0", out_ovf); end
        if (err_drop !== 1'b0)  begin errors++; $display("FAIL reset_err_drop: got %b expected 0", err_drop); end
        if (in_ready !== 1'b1)  begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        longint t[$] = '{3, -5, 7, 100};
        longint res; bit ov;
        logic [AW-1:0] exp;
        model_dot(t, AW, res, ov);
        exp = res[AW-1:0];
        out_ready = 1'b1;
        issue(3, 0); issue(-5, 0); issue(7, 0); issue(100, 1);
        tick(); tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %b expected 0", out_valid); end
        tick();
        checks += 4;
        if (out_valid !== 1'b1)  begin errors++; $display("FAIL basic_valid_latency: got %b expected 1", out_valid); end
        if (out_data !== exp)    begin errors++; $display("FAIL basic_data: got %0d expected %0d", $signed(out_data), $signed(exp)); end
        if (out_data !== 40'd105) begin errors++; $display("FAIL basic_data_105: got %0d expected 105", $signed(out_data)); end
        if (out_ovf !== ov)      begin errors++; $display("FAIL basic_ovf: got %b expected %b", out_ovf, ov); end
        tick();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_popped: got %b expected 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        longint t[$];
        longint exp_q[$];
        bit     ovf_q[$];
        longint res, p;
        bit ov, ok;
        int len, a, b;
        logic [AW-1:0] exp;
        for (int k = 0; k < 4; k++) begin
            for (int d = 0; d < 2; d++) begin
                len = $urandom_range(1, 5);
                t.delete();
                for (int j = 0; j < len; j++) begin
                    a = $signed(16'($urandom));
                    b = $signed(16'($urandom));
                    p = longint'(a) * longint'(b);
                    t.push_back(p);
                    issue(p, j == len - 1);
                end
                model_dot(t, AW, res, ov);
                exp_q.push_back(res);
                ovf_q.push_back(ov);
            end
            for (int r = 0; r < 2; r++) begin
                wait_out("b2b", ok);
                if (ok) begin
                    res = exp_q.pop_front();
                    ov  = ovf_q.pop_front();
                    exp = res[AW-1:0];
                    checks += 2;
                    if (out_data !== exp) begin errors++; $display("FAIL b2b_data[%0d.%0d]: got %0d expected %0d", k, r, $signed(out_data), $signed(exp)); end
                    if (out_ovf !== ov)   begin errors++; $display("FAIL b2b_ovf[%0d.%0d]: got %b expected %b", k, r, out_ovf, ov); end
                    pop();
                end
            end
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        out_ready = 1'b0;
        checks++;
        if (err_drop !== 1'b0) begin errors++; $display("FAIL bp_err_pre: got %b expected 0", err_drop); end
        issue(1, 1);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after1: got %b expected 1", in_ready); end
        issue(2, 1);
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_after2: got %b expected 0", in_ready); end
        issue(3, 1);
        checks++;
        if (err_drop !== 1'b1) begin errors++; $display("FAIL bp_err_drop: got %b expected 1", err_drop); end
        repeat (5) tick();
        checks += 3;
        if (in_ready !== 1'b0)    begin errors++; $display("FAIL bp_ready_full: got %b expected 0", in_ready); end
        if (out_valid !== 1'b1)   begin errors++; $display("FAIL bp_valid_full: got %b expected 1", out_valid); end
        if (out_data !== 40'd1)   begin errors++; $display("FAIL bp_head1: got %0d expected 1", $signed(out_data)); end
        pop();
        checks += 2;
        if (in_ready !== 1'b1)  begin errors++; $display("FAIL bp_ready_after_pop: got %b expected 1", in_ready); end
        if (out_data !== 40'd2) begin errors++; $display("FAIL bp_head2: got %0d expected 2", $signed(out_data)); end
        issue(3, 1);
        pop();
        wait_out("bp_third", ok);
        if (ok) begin
            checks++;
            if (out_data !== 40'd3) begin errors++; $display("FAIL bp_head3: got %0d expected 3", $signed(out_data)); end
            pop();
        end
        checks++;
        if (err_drop !== 1'b1) begin errors++; $display("FAIL bp_err_sticky: got %b expected 1", err_drop); end
    endtask

    task automatic test_drop();
        bit ok;
        do_reset();
        checks++;
        if (err_drop !== 1'b0) begin errors++; $display("FAIL drop_err_cleared: got %b expected 0", err_drop); end
        out_ready = 1'b0;
        issue(7, 1); issue(8, 1);
        issue(1000, 0);
        repeat (6) tick();
        checks++;
        if (err_drop !== 1'b1) begin errors++; $display("FAIL drop_err_set: got %b expected 1", err_drop); end
        checks++;
        if (out_data !== 40'd7) begin errors++; $display("FAIL drop_head7: got %0d expected 7", $signed(out_data)); end
        pop();
        checks++;
        if (out_data !== 40'd8) begin errors++; $display("FAIL drop_head8: got %0d expected 8", $signed(out_data)); end
        pop();
        issue(5, 1);
        wait_out("drop_single", ok);
        if (ok) begin
            checks++;
            if (out_data !== 40'd5) begin errors++; $display("FAIL drop_not_accum: got %0d expected 5", $signed(out_data)); end
            pop();
        end
        checks++;
        if (err_drop !== 1'b1) begin errors++; $display("FAIL drop_err_sticky: got %b expected 1", err_drop); end
        do_reset();
        checks++;
        if (err_drop !== 1'b0) begin errors++; $display("FAIL drop_err_rst: got %b expected 0", err_drop); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        out_ready = 1'b0;
        issue(11, 0); issue(22, 0);
        do_reset();
        issue(10, 0); issue(20, 1);
        wait_out("rstmid", ok);
        if (ok) begin
            checks += 2;
            if (out_data !== 40'd30) begin errors++; $display("FAIL rstmid_data: got %0d expected 30", $signed(out_data)); end
            if (out_ovf !== 1'b0)    begin errors++; $display("FAIL rstmid_ovf: got %b expected 0", out_ovf); end
            pop();
        end
        repeat (6) tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_stale: got %b expected 0", out_valid); end
    endtask

    task automatic test_push_pop();
        bit ok;
        logic [AW-1:0] exp;
        longint m42 = -42;
        exp = m42[AW-1:0];
        out_ready = 1'b0;
        issue(41, 1);
        wait_out("pp_first", ok);
        issue(-42, 1);
        tick(); tick();
        checks++;
        if (out_data !== 40'd41) begin errors++; $display("FAIL pp_head41: got %0d expected 41", $signed(out_data)); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks += 2;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL pp_valid: got %b expected 1", out_valid); end
        if (out_data !== exp)   begin errors++; $display("FAIL pp_new_head: got %0d expected -42", $signed(out_data)); end
        pop();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL pp_count1: got %b expected 0", out_valid); end
    endtask

    task automatic run_b(input string name, input longint t[$]);
        longint res; bit ov, ok;
        logic [AW2-1:0] exp;
        foreach (t[i]) issue_b(t[i], i == t.size() - 1);
        model_dot(t, AW2, res, ov);
        exp = res[AW2-1:0];
        wait_b(name, ok);
        if (ok) begin
            checks += 2;
            if (b_data !== exp) begin errors++; $display("FAIL %s_data: got %h expected %h", name, b_data, exp); end
            if (b_ovf !== ov)   begin errors++; $display("FAIL %s_ovf: got %b expected %b", name, b_ovf, ov); end
            b_oready = 1'b1; tick(); b_oready = 1'b0;
        end
    endtask

    task automatic test_overflow();
        longint t[$];
        logic [AW2-1:0] lit;
        bit ok;
`ifdef PE_ACC_SATURATE_EN
        lit = 34'h1FFFFFFFF;
`else
        lit = 34'h27FFFFFFB;
`endif
        checks++;
        if (b_rdy !== 1'b1) begin errors++; $display("FAIL ovf_ready: got %b expected 1", b_rdy); end
        t = '{64'h7FFFFFFF, 64'h7FFFFFFF, 64'h7FFFFFFF, 64'h7FFFFFFF, 64'h7FFFFFFF};
        foreach (t[i]) issue_b(t[i], i == 4);
        wait_b("ovf_pos_lit", ok);
        if (ok) begin
            checks += 2;
            if (b_data !== lit)  begin errors++; $display("FAIL ovf_pos_lit_data: got %h expected %h", b_data, lit); end
            if (b_ovf !== 1'b1)  begin errors++; $display("FAIL ovf_pos_lit_ovf: got %b expected 1", b_ovf); end
            b_oready = 1'b1; tick(); b_oready = 1'b0;
        end
        run_b("ovf_pos", t);
        t = '{-64'sh80000000, -64'sh80000000, -64'sh80000000, -64'sh80000000, -64'sh80000000};
        run_b("ovf_neg", t);
        t = '{64'h7FFFFFFF, 64'h7FFFFFFF, 64'h7FFFFFFF, 64'h7FFFFFFF, 64'h7FFFFFFF,
              -64'sh7FFFFFFF, -64'sh7FFFFFFF, -64'sh7FFFFFFF};
        run_b("ovf_sticky", t);
        for (int k = 0; k < 4; k++) begin
            t.delete();
            for (int j = 0; j < int'($urandom_range(3, 8)); j++)
                t.push_back(longint'($signed($urandom)));
            run_b("ovf_rand", t);
        end
        checks++;
        if (b_err !== 1'b0) begin errors++; $display("FAIL ovf_err_drop: got %b expected 0", b_err); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_last = 1'b0; pin = '0; out_ready = 1'b0;
        b_valid = 1'b0; b_last = 1'b0; b_pin = '0; b_oready = 1'b0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_drop();
        test_reset_mid();
        test_push_pop();
        test_overflow();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
